// File: rtl/serial_subtractor_14_pkg.sv
// Shared arithmetic package for the serial adder/subtractor family:
// default operand width, FSM state encoding and counter sizing helper.
package arith_pkg;

    localparam int WIDTH_DEFAULT = 14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_subtractor_14_if.sv
// Start/done operation bus between a controller (master) and the serial
// subtractor (slave).
interface serial_subtractor_14_if
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;
    logic             busy;
    logic             done;

    modport master (
        output start, a, b,
        input  diff, borrow_out, overflow, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, borrow_out, overflow, busy, done
    );

endinterface

// File: rtl/serial_subtractor_14_full_adder_1b.sv
// Single-bit full-adder cell shared by the serial adder and subtractor.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_subtractor_14.sv
// Bit-serial a - b (LSB first) computed as a + ~b + 1 through one full-adder
// cell, behind a start/done handshake. One result bit per clock.
module serial_subtractor_14
    import arith_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_subtractor_14_if.slave  bus
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;

    logic b_inv;
    logic fa_s;
    logic fa_cout;

    assign b_inv = ~b_q[0];

    full_adder_1b u_fa (
        .a    (a_q[0]),
        .b    (b_inv),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    // Operands rotate rather than shift so that, on the final bit, a_q[0] and
    // b_q[0] are the original sign bits needed for the overflow flag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = {a_q[0], a_q[WIDTH-1:1]};
                b_d     = {b_q[0], b_q[WIDTH-1:1]};
                diff_d  = {fa_s, diff_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    state_d  = DONE;
                    borrow_d = ~fa_cout;
                    ovf_d    = (a_q[0] != b_q[0]) && (fa_s != a_q[0]);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);

endmodule
